// File: rtl/ps2_mailbox_pkg.sv
// Shared types and constants for the PS/2 keyboard mailbox: FSM states,
// prefix scancodes and the layout of the 32-bit status word.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   localparam int MB_CODE_LSB  = 0;
   localparam int MB_CODE_W    = 8;
   localparam int MB_BREAK_BIT = 8;
   localparam int MB_EXT_BIT   = 9;
   localparam int MB_EVT_LSB   = 16;
   localparam int MB_EVT_W     = 8;
   localparam int MB_ERR_LSB   = 24;
   localparam int MB_ERR_W     = 7;

   localparam int MAILBOX_WORD = 510;

   // Unlisted bits ([15:10] and [31]) stay zero.
   function automatic logic [31:0] pack_mailbox(
      input logic [MB_CODE_W-1:0] code,
      input logic                 brk,
      input logic                 ext,
      input logic [MB_EVT_W-1:0]  evt,
      input logic [MB_ERR_W-1:0]  err
   );
      logic [31:0] mb;
      mb = '0;
      mb[MB_CODE_LSB +: MB_CODE_W] = code;
      mb[MB_BREAK_BIT]             = brk;
      mb[MB_EXT_BIT]               = ext;
      mb[MB_EVT_LSB +: MB_EVT_W]   = evt;
      mb[MB_ERR_LSB +: MB_ERR_W]   = err;
      return mb;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the PS/2 pins plus a history flop on the clock
// line; fall marks a synchronised high-to-low transition of ps2_clk.
module ps2_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_s,
   output logic fall
);

   logic clk_s1_q, clk_s2_q, clk_hist_q;
   logic data_s1_q, data_s2_q;

   // Reset to the idle line level so leaving reset never looks like an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_hist_q <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         clk_hist_q <= clk_s2_q;
         data_s1_q  <= ps2_data;
         data_s2_q  <= data_s1_q;
      end
   end

   assign data_s = data_s2_q;
   assign fall   = clk_hist_q & ~clk_s2_q;

endmodule

// File: rtl/ps2_mailbox.sv
// PS/2 keyboard receiver feeding a polled 32-bit status word: deserialises
// frames, folds F0/E0 prefixes into flags and keeps event/error counts.
module ps2_mailbox
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = 100_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [31:0] mailbox,
   output logic        key_strobe,
   output logic        frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

   logic data_s, fall;

   ps2_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .data_s   (data_s),
      .fall     (fall)
   );

   ps2_state_t             state_q;
   logic [2:0]             bit_idx_q;
   logic [7:0]             shift_q;
   logic                   parity_q;
   logic [TW-1:0]          tmo_q;
   logic                   pend_break_q, pend_ext_q;
   logic [MB_CODE_W-1:0]   code_q;
   logic                   brk_q, ext_q;
   logic [MB_EVT_W-1:0]    evt_cnt_q;
   logic [MB_ERR_W-1:0]    err_cnt_q;
   logic                   key_strobe_q, frame_err_q;

   logic tmo_fire, stop_edge, frame_ok, err_evt, key_evt, brk_evt, ext_evt;
   logic [MB_ERR_W-1:0] err_cnt_d;

   // A timeout in the same cycle as an edge takes priority and swallows it.
   always_comb begin
      tmo_fire  = (state_q != ST_IDLE) && (tmo_q == TMO_MAX);
      stop_edge = !tmo_fire && fall && (state_q == ST_STOP);
      frame_ok  = data_s && ((^shift_q) ^ parity_q);
      err_evt   = tmo_fire || (stop_edge && !frame_ok);
      brk_evt   = stop_edge && frame_ok && (shift_q == PS2_BREAK);
      ext_evt   = stop_edge && frame_ok && (shift_q == PS2_EXT);
      key_evt   = stop_edge && frame_ok && !brk_evt && !ext_evt;
      err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         tmo_q        <= '0;
         pend_break_q <= 1'b0;
         pend_ext_q   <= 1'b0;
         code_q       <= '0;
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         evt_cnt_q    <= '0;
         err_cnt_q    <= '0;
         key_strobe_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         key_strobe_q <= key_evt;
         frame_err_q  <= err_evt;

         if (tmo_fire) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
         end else begin
            if (state_q == ST_IDLE || fall)
               tmo_q <= '0;
            else
               tmo_q <= tmo_q + TW'(1);

            if (fall) begin
               case (state_q)
                  ST_IDLE: begin
                     // A high data bit here is line noise, not a start bit.
                     if (!data_s) begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                     end
                  end
                  ST_DATA: begin
                     shift_q   <= {data_s, shift_q[7:1]};
                     bit_idx_q <= bit_idx_q + 3'd1;
                     if (bit_idx_q == 3'd7)
                        state_q <= ST_PARITY;
                  end
                  ST_PARITY: begin
                     parity_q <= data_s;
                     state_q  <= ST_STOP;
                  end
                  ST_STOP: begin
                     state_q <= ST_IDLE;
                  end
                  default: state_q <= ST_IDLE;
               endcase
            end
         end

         if (err_evt) begin
            err_cnt_q    <= err_cnt_d;
            pend_break_q <= 1'b0;
            pend_ext_q   <= 1'b0;
         end else if (key_evt) begin
            code_q       <= shift_q;
            brk_q        <= pend_break_q;
            ext_q        <= pend_ext_q;
            evt_cnt_q    <= evt_cnt_q + 1'b1;
            pend_break_q <= 1'b0;
            pend_ext_q   <= 1'b0;
         end else begin
            if (brk_evt) pend_break_q <= 1'b1;
            if (ext_evt) pend_ext_q   <= 1'b1;
         end
      end
   end

   assign mailbox    = pack_mailbox(code_q, brk_q, ext_q, evt_cnt_q, err_cnt_q);
   assign key_strobe = key_strobe_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_mailbox.sv
// Directed bench for ps2_mailbox: bit-bangs PS/2 frames on the pins and
// checks the status word, strobe and error pulses against hand-computed values.
module tb_ps2_mailbox;

   localparam int TMO  = 200;
   localparam int HALF = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [31:0] mailbox;
   logic        key_strobe;
   logic        frame_err;

   int n_cmp = 0;
   int n_bad = 0;
   int strobe_cnt = 0;
   int ferr_cnt = 0;
   logic both_seen = 1'b0;
   logic [31:0] strobe_mb = '0;

   ps2_mailbox #(.TIMEOUT_CYC(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .mailbox    (mailbox),
      .key_strobe (key_strobe),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_strobe) begin
         strobe_cnt++;
         strobe_mb = mailbox;
      end
      if (frame_err) ferr_cnt++;
      if (key_strobe && frame_err) both_seen = 1'b1;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad);
      return {1'b1, (~^d) ^ bad, d, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_cyc(10);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic bad);
      send_bits(mk_frame(d, bad), 11);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_cyc(4);
      rst = 1'b0;
      wait_cyc(4);
      @(negedge clk);
      n_cmp++;
      if (mailbox !== 32'h0) begin n_bad++; $display("FAIL reset_mailbox: got %h want %h", mailbox, 32'h0); end
      n_cmp++;
      if (key_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", key_strobe); end
      n_cmp++;
      if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
      $display("test_reset: mailbox=%h", mailbox);
   endtask

   task automatic test_single_key();
      int s0, e0;
      s0 = strobe_cnt; e0 = ferr_cnt;
      send_byte(8'h1C, 1'b0);
      n_cmp++;
      if (mailbox !== 32'h0001_001C) begin n_bad++; $display("FAIL single_mailbox: got %h want %h", mailbox, 32'h0001_001C); end
      n_cmp++;
      if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL single_strobes: got %0d want 1", strobe_cnt - s0); end
      n_cmp++;
      if (strobe_mb !== 32'h0001_001C) begin n_bad++; $display("FAIL single_strobe_value: got %h want %h", strobe_mb, 32'h0001_001C); end
      n_cmp++;
      if (ferr_cnt - e0 !== 0) begin n_bad++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt - e0); end
      $display("test_single_key: 1C -> mailbox=%h", mailbox);
   endtask

   task automatic test_break();
      int s0;
      s0 = strobe_cnt;
      send_byte(8'hF0, 1'b0);
      n_cmp++;
      if (strobe_cnt - s0 !== 0) begin n_bad++; $display("FAIL break_prefix_strobe: got %0d want 0", strobe_cnt - s0); end
      n_cmp++;
      if (mailbox !== 32'h0001_001C) begin n_bad++; $display("FAIL break_prefix_mailbox: got %h want %h", mailbox, 32'h0001_001C); end
      send_byte(8'h1C, 1'b0);
      n_cmp++;
      if (mailbox !== 32'h0002_011C) begin n_bad++; $display("FAIL break_mailbox: got %h want %h", mailbox, 32'h0002_011C); end
      $display("test_break: F0 1C -> mailbox=%h", mailbox);
   endtask

   task automatic test_ext_break();
      int s0;
      s0 = strobe_cnt;
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h75, 1'b0);
      n_cmp++;
      if (mailbox !== 32'h0003_0375) begin n_bad++; $display("FAIL ext_break_mailbox: got %h want %h", mailbox, 32'h0003_0375); end
      n_cmp++;
      if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL ext_break_strobes: got %0d want 1", strobe_cnt - s0); end
      $display("test_ext_break: E0 F0 75 -> mailbox=%h", mailbox);
   endtask

   task automatic test_parity_err();
      int s0, e0;
      s0 = strobe_cnt; e0 = ferr_cnt;
      send_byte(8'h1C, 1'b1);
      n_cmp++;
      if (ferr_cnt - e0 !== 1) begin n_bad++; $display("FAIL parity_ferr: got %0d want 1", ferr_cnt - e0); end
      n_cmp++;
      if (strobe_cnt - s0 !== 0) begin n_bad++; $display("FAIL parity_strobe: got %0d want 0", strobe_cnt - s0); end
      n_cmp++;
      if (mailbox !== 32'h0103_0375) begin n_bad++; $display("FAIL parity_mailbox: got %h want %h", mailbox, 32'h0103_0375); end
      send_byte(8'h1B, 1'b0);
      n_cmp++;
      if (mailbox !== 32'h0104_001B) begin n_bad++; $display("FAIL parity_next_mailbox: got %h want %h", mailbox, 32'h0104_001B); end
      $display("test_parity_err: bad 1C, 1B -> mailbox=%h", mailbox);
   endtask

   task automatic test_glitch();
      int s0, e0;
      s0 = strobe_cnt; e0 = ferr_cnt;
      send_bits(11'h7FF, 1);
      wait_cyc(TMO + 20);
      n_cmp++;
      if ((strobe_cnt - s0) + (ferr_cnt - e0) !== 0) begin n_bad++; $display("FAIL glitch_events: got %0d want 0", (strobe_cnt - s0) + (ferr_cnt - e0)); end
      n_cmp++;
      if (mailbox !== 32'h0104_001B) begin n_bad++; $display("FAIL glitch_mailbox: got %h want %h", mailbox, 32'h0104_001B); end
      $display("test_glitch: mailbox=%h", mailbox);
   endtask

   task automatic test_timeout();
      int e0;
      e0 = ferr_cnt;
      send_bits(mk_frame(8'h1C, 1'b0), 5);
      wait_cyc(TMO - 30);
      n_cmp++;
      if (ferr_cnt - e0 !== 0) begin n_bad++; $display("FAIL timeout_early: got %0d want 0", ferr_cnt - e0); end
      wait_cyc(40);
      n_cmp++;
      if (ferr_cnt - e0 !== 1) begin n_bad++; $display("FAIL timeout_ferr: got %0d want 1", ferr_cnt - e0); end
      n_cmp++;
      if (mailbox !== 32'h0204_001B) begin n_bad++; $display("FAIL timeout_mailbox: got %h want %h", mailbox, 32'h0204_001B); end
      send_byte(8'h1C, 1'b0);
      n_cmp++;
      if (mailbox !== 32'h0205_001C) begin n_bad++; $display("FAIL timeout_recover: got %h want %h", mailbox, 32'h0205_001C); end
      $display("test_timeout: mailbox=%h", mailbox);
   endtask

   task automatic test_wrap_saturate();
      int s0, e0;
      e0 = ferr_cnt;
      send_bits(mk_frame(8'h33, 1'b0), 3);
      rst = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(TMO + 20);
      n_cmp++;
      if (ferr_cnt - e0 !== 0) begin n_bad++; $display("FAIL midreset_ferr: got %0d want 0", ferr_cnt - e0); end
      n_cmp++;
      if (mailbox !== 32'h0) begin n_bad++; $display("FAIL midreset_mailbox: got %h want %h", mailbox, 32'h0); end
      s0 = strobe_cnt;
      for (int i = 0; i < 255; i++) send_byte(8'h15, 1'b0);
      n_cmp++;
      if (mailbox !== 32'h00FF_0015) begin n_bad++; $display("FAIL evt_255: got %h want %h", mailbox, 32'h00FF_0015); end
      send_byte(8'h15, 1'b0);
      n_cmp++;
      if (mailbox !== 32'h0000_0015) begin n_bad++; $display("FAIL evt_wrap: got %h want %h", mailbox, 32'h0000_0015); end
      n_cmp++;
      if (strobe_cnt - s0 !== 256) begin n_bad++; $display("FAIL evt_strobes: got %0d want 256", strobe_cnt - s0); end
      e0 = ferr_cnt;
      for (int i = 0; i < 127; i++) send_byte(8'h15, 1'b1);
      n_cmp++;
      if (mailbox !== 32'h7F00_0015) begin n_bad++; $display("FAIL err_127: got %h want %h", mailbox, 32'h7F00_0015); end
      for (int i = 0; i < 3; i++) send_byte(8'h15, 1'b1);
      n_cmp++;
      if (mailbox !== 32'h7F00_0015) begin n_bad++; $display("FAIL err_saturate: got %h want %h", mailbox, 32'h7F00_0015); end
      n_cmp++;
      if (ferr_cnt - e0 !== 130) begin n_bad++; $display("FAIL err_pulses: got %0d want 130", ferr_cnt - e0); end
      n_cmp++;
      if (both_seen !== 1'b0) begin n_bad++; $display("FAIL strobe_and_ferr_together: got %b want 0", both_seen); end
      $display("test_wrap_saturate: mailbox=%h", mailbox);
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_break();
      test_ext_break();
      test_parity_err();
      test_glitch();
      test_timeout();
      test_wrap_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
